// File: rtl/lynxTypes.sv
// lynxTypes: shared listen request/response types and helpers for the TCP port table path.
package lynxTypes;
  localparam int VFID_BITS = 4;
  localparam int PID_BITS = 6;
  localparam int DEST_BITS = 4;
  localparam logic [15:0] TCP_PORT_OFFS = 16'd0;
  typedef struct packed {
    logic [VFID_BITS-1:0] vfid;
    logic [DEST_BITS-1:0] dest;
    logic [PID_BITS-1:0] pid;
    logic [15:0] ip_port;
  } listen_req_t;
  typedef struct packed {
    logic [VFID_BITS-1:0] vfid;
    logic open_port_success;
  } listen_rsp_t;
  localparam int LISTEN_REQ_BITS = $bits(listen_req_t);
  localparam int LISTEN_RSP_BITS = $bits(listen_rsp_t);
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return v == 16'hFFFF ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/tcp_listen_arbiter_if.sv
// tcp_listen_arbiter_if: per-region listen request/response channels plus the shared port-table side.
interface tcp_listen_arbiter_if import lynxTypes::*; #(parameter int N_REGIONS = 4);
  logic [N_REGIONS-1:0] s_req_valid, s_req_ready;
  listen_req_t [N_REGIONS-1:0] s_req_data;
  logic m_req_valid, m_req_ready;
  listen_req_t m_req_data;
  logic s_rsp_valid, s_rsp_ready;
  listen_rsp_t s_rsp_data;
  logic [N_REGIONS-1:0] m_rsp_valid, m_rsp_ready;
  listen_rsp_t m_rsp_data;
  logic [15:0] stat_timeouts, stat_dropped;
  modport slave(
    input s_req_valid, s_req_data, m_req_ready, s_rsp_valid, s_rsp_data, m_rsp_ready,
    output s_req_ready, m_req_valid, m_req_data, s_rsp_ready, m_rsp_valid, m_rsp_data,
    stat_timeouts, stat_dropped
  );
  modport master(
    output s_req_valid, s_req_data, m_req_ready, s_rsp_valid, s_rsp_data, m_rsp_ready,
    input s_req_ready, m_req_valid, m_req_data, s_rsp_ready, m_rsp_valid, m_rsp_data,
    stat_timeouts, stat_dropped
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requesting index strictly after last, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx,
  output logic          any
);
  logic [IW:0] j;
  always_comb begin
    grant_idx = '0;
    any = 1'b0;
    j = '0;
    for (int i = N; i >= 1; i--) begin
      j = {1'b0, last} + (IW+1)'(i);
      j = j >= (IW+1)'(N) ? j - (IW+1)'(N) : j;
      if (req[j[IW-1:0]]) begin
        grant_idx = j[IW-1:0];
        any = 1'b1;
      end
    end
    grant_oh = any ? N'(1) << grant_idx : '0;
  end
endmodule

// File: rtl/tcp_listen_arbiter.sv
// tcp_listen_arbiter: round-robin funnel of vFPGA listen requests into one port-table channel,
// one request outstanding, with response timeout and late-response accounting.
module tcp_listen_arbiter import lynxTypes::*; #(
  parameter int N_REGIONS = 4,
  parameter int RSP_TIMEOUT = 1024
) (
  input logic aclk,
  input logic aresetn,
  tcp_listen_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REGIONS);
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_RSP} state_t;
  state_t state, state_n;
  logic [IW-1:0] last_grant, grant, arb_idx;
  logic [N_REGIONS-1:0] arb_oh;
  logic arb_any, timeout;
  listen_req_t req_q, req_sel;
  listen_rsp_t rsp_q;
  logic [15:0] cnt, timeouts_q, dropped_q;
  rr_arbiter #(.N(N_REGIONS)) u_rr (
    .req(bus.s_req_valid),
    .last(last_grant),
    .grant_oh(arb_oh),
    .grant_idx(arb_idx),
    .any(arb_any)
  );
  assign timeout = cnt == 16'(RSP_TIMEOUT - 1);
  assign bus.stat_timeouts = timeouts_q;
  assign bus.stat_dropped = dropped_q;
  always_comb begin
    state_n = state;
    req_sel = bus.s_req_data[arb_idx];
    req_sel.vfid = VFID_BITS'(arb_idx);
    bus.s_req_ready = '0;
    bus.m_req_valid = state == ST_SEND;
    bus.m_req_data = req_q;
    bus.s_rsp_ready = aresetn;
    bus.m_rsp_valid = '0;
    bus.m_rsp_data = rsp_q;
    case (state)
      ST_IDLE: begin
        bus.s_req_ready = aresetn ? arb_oh : '0;
        state_n = arb_any ? ST_SEND : ST_IDLE;
      end
      ST_SEND: state_n = bus.m_req_ready ? ST_WAIT : ST_SEND;
      ST_WAIT: state_n = bus.s_rsp_valid || timeout ? ST_RSP : ST_WAIT;
      default: begin
        bus.m_rsp_valid[grant] = 1'b1;
        state_n = bus.m_rsp_ready[grant] ? ST_IDLE : ST_RSP;
      end
    endcase
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= ST_IDLE;
      last_grant <= IW'(N_REGIONS - 1);
      cnt <= '0;
      timeouts_q <= '0;
      dropped_q <= '0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && arb_any) last_grant <= arb_idx;
      cnt <= state == ST_SEND ? '0 : state == ST_WAIT ? cnt + 16'd1 : cnt;
      if (state == ST_WAIT && !bus.s_rsp_valid && timeout) timeouts_q <= sat_inc(timeouts_q);
      if (state != ST_WAIT && bus.s_rsp_valid) dropped_q <= sat_inc(dropped_q);
    end
  end
  // Payload registers carry no reset: their contents are only observed behind a valid.
  always_ff @(posedge aclk) begin
    if (state == ST_IDLE && arb_any) begin
      grant <= arb_idx;
      req_q <= req_sel;
    end
    if (state == ST_WAIT && bus.s_rsp_valid) rsp_q <= bus.s_rsp_data;
    else if (state == ST_WAIT && timeout) rsp_q <= '{vfid: VFID_BITS'(grant), open_port_success: 1'b0};
  end
endmodule

// File: tb/tb_tcp_listen_arbiter.sv
// tb_tcp_listen_arbiter: randomized scenario bench with a transaction-level model of the arbiter.
module tb_tcp_listen_arbiter;
  import lynxTypes::*;
  localparam int N = 4;
  localparam int T = 1024;
  localparam int IW = $clog2(N);
  logic aclk, aresetn;
  int n_tests, n_fail;
  int m_last, m_to, m_drop;
  tcp_listen_arbiter_if #(.N_REGIONS(N)) bus ();
  tcp_listen_arbiter #(.N_REGIONS(N), .RSP_TIMEOUT(T)) dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got hang, required completion");
    $fatal(1, "watchdog");
  end
  function automatic int pick(input logic [N-1:0] m, input int last);
    for (int i = 1; i <= N; i++)
      if ((m & (N'(1) << ((last + i) % N))) != '0) return (last + i) % N;
    return -1;
  endfunction
  function automatic listen_req_t rnd_req();
    return listen_req_t'(LISTEN_REQ_BITS'($urandom));
  endfunction
  task automatic txn(input logic [N-1:0] mask, input listen_req_t [N-1:0] d, input int req_lat,
                     input int rsp_lat, input listen_rsp_t rsp, output int g, output logic [N-1:0] rdy,
                     output listen_req_t got_req, output logic stable, output logic [N-1:0] got_v,
                     output listen_rsp_t got_rsp);
    int n;
    bus.s_req_data = d;
    bus.s_req_valid = mask;
    #1;
    rdy = bus.s_req_ready;
    g = -1;
    for (int i = 0; i < N; i++) if (rdy == N'(1) << i) g = i;
    @(negedge aclk);
    bus.s_req_valid = bus.s_req_valid & ~rdy;
    stable = 1'b1;
    got_req = bus.m_req_data;
    for (int k = 0; k <= req_lat; k++) begin
      if (bus.m_req_valid !== 1'b1 || bus.m_req_data !== got_req || bus.s_req_ready !== '0) stable = 1'b0;
      if (k < req_lat) @(negedge aclk);
    end
    bus.m_req_ready = 1'b1;
    @(negedge aclk);
    bus.m_req_ready = 1'b0;
    if (rsp_lat >= 0) begin
      repeat (rsp_lat) @(negedge aclk);
      bus.s_rsp_valid = 1'b1;
      bus.s_rsp_data = rsp;
      @(negedge aclk);
      bus.s_rsp_valid = 1'b0;
    end
    n = 0;
    while (bus.m_rsp_valid == '0 && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    got_v = bus.m_rsp_valid;
    got_rsp = bus.m_rsp_data;
    bus.m_rsp_ready = got_v;
    @(negedge aclk);
    bus.m_rsp_ready = '0;
  endtask
  task automatic test_reset();
    aresetn = 1'b0;
    bus.s_req_valid = '1;
    repeat (3) @(negedge aclk);
    n_tests++;
    if (bus.s_req_ready !== '0 || bus.m_req_valid !== 1'b0 || bus.m_rsp_valid !== '0 || bus.s_rsp_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req_rdy=%b m_req_v=%b m_rsp_v=%b rsp_rdy=%b, required all 0",
               bus.s_req_ready, bus.m_req_valid, bus.m_rsp_valid, bus.s_rsp_ready);
    end
    n_tests++;
    if (bus.stat_timeouts !== 16'd0 || bus.stat_dropped !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_stats: got %0d/%0d, required 0/0", bus.stat_timeouts, bus.stat_dropped);
    end
    bus.s_req_valid = '0;
    aresetn = 1'b1;
    m_last = N - 1; m_to = 0; m_drop = 0;
    #1;
    n_tests++;
    if (bus.s_rsp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_rsp_ready: got %b, required 1", bus.s_rsp_ready);
    end
  endtask
  task automatic test_basic();
    listen_req_t [N-1:0] d;
    listen_req_t e, gr;
    listen_rsp_t r, gs;
    logic [N-1:0] rdy, gv;
    logic st;
    int g;
    for (int i = 0; i < N; i++) d[i] = rnd_req();
    d[0].ip_port = 16'd5001;
    e = d[0];
    e.vfid = '0;
    r = '{vfid: 4'd0, open_port_success: 1'b1};
    txn(4'b0001, d, 0, 3, r, g, rdy, gr, st, gv, gs);
    m_last = 0;
    n_tests++;
    if (g !== 0 || gr !== e) begin
      n_fail++;
      $display("FAIL basic_request: got grant %0d data %h, required grant 0 data %h", g, gr, e);
    end
    n_tests++;
    if (gv !== 4'b0001 || gs !== r) begin
      n_fail++;
      $display("FAIL basic_response: got valid %b data %h, required 0001 %h", gv, gs, r);
    end
    n_tests++;
    if (bus.stat_timeouts !== 16'd0 || bus.stat_dropped !== 16'd0) begin
      n_fail++;
      $display("FAIL basic_stats: got %0d/%0d, required 0/0", bus.stat_timeouts, bus.stat_dropped);
    end
  endtask
  task automatic test_round_robin();
    listen_req_t [N-1:0] d;
    listen_req_t gr;
    listen_rsp_t gs;
    logic [N-1:0] rdy, gv;
    logic st;
    int g, exp_g;
    int seq [4] = '{1, 3, 1, 3};
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) d[i] = rnd_req();
      exp_g = pick(4'b1010, m_last);
      txn(4'b1010, d, 0, 0, '{vfid: 4'(seq[t]), open_port_success: 1'b1}, g, rdy, gr, st, gv, gs);
      n_tests++;
      if (g !== seq[t] || g !== exp_g || gv !== N'(1) << seq[t]) begin
        n_fail++;
        $display("FAIL rr_alternate[%0d]: got grant %0d rsp_v %b, required %0d", t, g, gv, seq[t]);
      end
      m_last = exp_g;
    end
  endtask
  task automatic test_stall();
    listen_req_t [N-1:0] d;
    listen_req_t e, gr;
    listen_rsp_t gs;
    logic [N-1:0] rdy, gv;
    logic st;
    int g, exp_g;
    for (int i = 0; i < N; i++) d[i] = rnd_req();
    exp_g = pick(4'b0111, m_last);
    e = d[IW'(exp_g)];
    e.vfid = 4'(exp_g);
    txn(4'b0111, d, 50, 1, '{vfid: 4'(exp_g), open_port_success: 1'b1}, g, rdy, gr, st, gv, gs);
    m_last = exp_g;
    n_tests++;
    if (st !== 1'b1 || gr !== e || g !== exp_g) begin
      n_fail++;
      $display("FAIL stall_stable: got stable %b data %h grant %0d, required 1 %h %0d", st, gr, g, e, exp_g);
    end
  endtask
  task automatic test_timeout();
    listen_req_t [N-1:0] d;
    listen_req_t gr;
    listen_rsp_t gs, e;
    logic [N-1:0] rdy, gv;
    logic st;
    int g;
    for (int i = 0; i < N; i++) d[i] = rnd_req();
    txn(4'b0100, d, 0, -1, '0, g, rdy, gr, st, gv, gs);
    m_last = 2; m_to++;
    e = '{vfid: 4'd2, open_port_success: 1'b0};
    n_tests++;
    if (gv !== 4'b0100 || gs !== e || bus.stat_timeouts !== 16'(m_to)) begin
      n_fail++;
      $display("FAIL timeout_rsp: got valid %b data %h timeouts %0d, required 0100 %h %0d",
               gv, gs, bus.stat_timeouts, e, m_to);
    end
    repeat (60) @(negedge aclk);
    bus.s_rsp_valid = 1'b1;
    bus.s_rsp_data = '{vfid: 4'd2, open_port_success: 1'b1};
    @(negedge aclk);
    bus.s_rsp_valid = 1'b0;
    m_drop++;
    n_tests++;
    if (bus.stat_dropped !== 16'(m_drop) || bus.m_rsp_valid !== '0) begin
      n_fail++;
      $display("FAIL late_drop: got dropped %0d rsp_v %b, required %0d 0000", bus.stat_dropped, bus.m_rsp_valid, m_drop);
    end
  endtask
  task automatic test_coincide();
    listen_req_t [N-1:0] d;
    listen_req_t gr;
    listen_rsp_t gs, r;
    logic [N-1:0] rdy, gv;
    logic st;
    int g, exp_g;
    for (int i = 0; i < N; i++) d[i] = rnd_req();
    exp_g = pick(4'b1000, m_last);
    r = '{vfid: 4'(exp_g), open_port_success: 1'b1};
    txn(4'b1000, d, 0, T - 1, r, g, rdy, gr, st, gv, gs);
    m_last = exp_g;
    n_tests++;
    if (gs !== r || gv !== 4'b1000 || bus.stat_timeouts !== 16'(m_to) || bus.stat_dropped !== 16'(m_drop)) begin
      n_fail++;
      $display("FAIL coincide: got data %h valid %b timeouts %0d dropped %0d, required %h 1000 %0d %0d",
               gs, gv, bus.stat_timeouts, bus.stat_dropped, r, m_to, m_drop);
    end
  endtask
  task automatic test_random();
    listen_req_t [N-1:0] d;
    listen_req_t e, gr;
    listen_rsp_t gs, r, er;
    logic [N-1:0] rdy, gv, m;
    logic st;
    int g, exp_g, rl, sel;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) d[i] = rnd_req();
      m = N'($urandom_range(1, (1 << N) - 1));
      sel = $urandom_range(0, 9);
      rl = sel == 9 ? -1 : sel == 8 ? T + 1 : sel;
      r = listen_rsp_t'(LISTEN_RSP_BITS'($urandom));
      exp_g = pick(m, m_last);
      e = d[IW'(exp_g)];
      e.vfid = 4'(exp_g);
      er = rl >= 0 && rl < T ? r : '{vfid: 4'(exp_g), open_port_success: 1'b0};
      if (rl < 0 || rl >= T) m_to++;
      if (rl >= T) m_drop++;
      txn(m, d, $urandom_range(0, 4), rl, r, g, rdy, gr, st, gv, gs);
      bus.s_req_valid = '0;
      m_last = exp_g;
      n_tests++;
      if (g !== exp_g || gr !== e || st !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_req[%0d]: got grant %0d data %h stable %b, required %0d %h 1", t, g, gr, st, exp_g, e);
      end
      n_tests++;
      if (gv !== N'(1) << exp_g || gs !== er) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d]: got valid %b data %h, required %b %h", t, gv, gs, N'(1) << exp_g, er);
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.s_rsp_valid = 1'b1;
        @(negedge aclk);
        bus.s_rsp_valid = 1'b0;
        m_drop++;
      end
      n_tests++;
      if (bus.stat_timeouts !== 16'(m_to) || bus.stat_dropped !== 16'(m_drop)) begin
        n_fail++;
        $display("FAIL rand_stats[%0d]: got %0d/%0d, required %0d/%0d", t, bus.stat_timeouts, bus.stat_dropped, m_to, m_drop);
      end
    end
  endtask
  task automatic test_reset_mid();
    listen_req_t [N-1:0] d;
    listen_req_t gr;
    listen_rsp_t gs;
    logic [N-1:0] rdy, gv;
    logic st;
    int g;
    for (int i = 0; i < N; i++) d[i] = rnd_req();
    bus.s_req_data = d;
    bus.s_req_valid = 4'b0010;
    @(negedge aclk);
    bus.s_req_valid = '0;
    bus.m_req_ready = 1'b1;
    @(negedge aclk);
    bus.m_req_ready = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    n_tests++;
    if (bus.m_rsp_valid !== '0 || bus.m_req_valid !== 1'b0 || bus.s_req_ready !== '0 || bus.s_rsp_ready !== 1'b0 ||
        bus.stat_timeouts !== 16'd0 || bus.stat_dropped !== 16'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got m_rsp_v=%b m_req_v=%b req_rdy=%b rsp_rdy=%b stats=%0d/%0d, required all 0",
               bus.m_rsp_valid, bus.m_req_valid, bus.s_req_ready, bus.s_rsp_ready, bus.stat_timeouts, bus.stat_dropped);
    end
    aresetn = 1'b1;
    m_last = N - 1; m_to = 0; m_drop = 0;
    txn(4'b1111, d, 0, 0, '{vfid: 4'd0, open_port_success: 1'b1}, g, rdy, gr, st, gv, gs);
    n_tests++;
    if (g !== 0 || gv !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset_next_grant: got grant %0d rsp_v %b, required 0 0001", g, gv);
    end
  endtask
  initial begin
    n_tests = 0; n_fail = 0;
    m_last = N - 1; m_to = 0; m_drop = 0;
    aresetn = 1'b0;
    bus.s_req_valid = '0; bus.s_req_data = '0; bus.m_req_ready = 1'b0;
    bus.s_rsp_valid = 1'b0; bus.s_rsp_data = '0; bus.m_rsp_ready = '0;
    @(negedge aclk);
    test_reset();
    test_basic();
    test_round_robin();
    test_stall();
    test_timeout();
    test_coincide();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tcp_listen_arbiter.md
TCP_LISTEN_ARBITER -- requirements
Module: tcp_listen_arbiter

Interface
REQ-001 Parameter N_REGIONS, default 4: number of vFPGA listen requesters, range 2..16.
REQ-002 Parameter RSP_TIMEOUT, default 1024: cycles to wait for a listen response before reporting failure, range 1..65535.
REQ-003 aclk  input  1  clock; all logic is rising-edge.
REQ-004 aresetn  input  1  reset, synchronous, active-low.
REQ-005 s_req_valid / s_req_ready  input / output  N_REGIONS each  per-region listen request handshake.
REQ-006 s_req_data  input  N_REGIONS x LISTEN_REQ_BITS  per region: ip_port[15:0], pid, dest.
REQ-007 m_req_valid / m_req_ready  output / input  1 each  shared listen request toward the port table.
REQ-008 m_req_data  output  LISTEN_REQ_BITS  granted region's request, with vfid = granted index inserted.
REQ-009 s_rsp_valid / s_rsp_ready  input / output  1 each  shared listen response from the port table.
REQ-010 s_rsp_data  input  LISTEN_RSP_BITS  response: open_port_success[0], vfid.
REQ-011 m_rsp_valid / m_rsp_ready  output / input  N_REGIONS each  per-region response handshake.
REQ-012 m_rsp_data  output  LISTEN_RSP_BITS  response broadcast to all regions; only the granted region's valid is asserted.
REQ-013 stat_timeouts, stat_dropped  output  16 each  saturating event counters.

Function
REQ-014 The FSM SHALL have states ST_IDLE, ST_SEND, ST_WAIT and ST_RSP, with exactly one request outstanding at a time.
REQ-015 In ST_IDLE with any s_req_valid set, the arbiter SHALL grant round-robin: first valid index strictly after last_grant, wrapping N_REGIONS-1 -> 0.
  - Asserts s_req_ready[grant] only, in the same cycle.
  - Latches data and grant.
  - Moves to ST_SEND.
REQ-016 last_grant SHALL reset to N_REGIONS-1, so index 0 wins first.
REQ-017 ST_SEND SHALL hold m_req_valid=1 with stable data until m_req_ready; on the handshake it moves to ST_WAIT and clears the timeout counter.
REQ-018 In ST_WAIT, s_rsp_ready=1.
  - On s_rsp_valid: latch the response, go to ST_RSP.
  - Otherwise increment the counter.
  - When the counter reaches RSP_TIMEOUT-1 without a response: latch open_port_success=0 with vfid=grant, increment stat_timeouts, go to ST_RSP.
REQ-019 If a response and the timeout coincide in the same cycle, the response SHALL win and stat_timeouts is not incremented.
REQ-020 ST_RSP SHALL assert m_rsp_valid[grant] with the latched data until m_rsp_ready[grant], then return to ST_IDLE.
REQ-021 A response whose vfid differs from grant SHALL still be delivered to the granted region.
REQ-022 In ST_IDLE, ST_SEND and ST_RSP, s_rsp_ready=1 and any arriving response SHALL be discarded and increment stat_dropped (late post-timeout responses).
REQ-023 Counters SHALL saturate at 16'hFFFF.
REQ-024 A request is accepted only in ST_IDLE; the minimum request-to-response path is 1 accept cycle + 1 send cycle + 1 wait cycle + 1 response cycle.
REQ-025 Requesters holding valid in non-IDLE states SHALL see ready=0 and are never starved: each waits at most N_REGIONS-1 other grants.

Reset
REQ-026 On aresetn=0 the block SHALL enter ST_IDLE, with:
  - all valid/ready outputs 0;
  - counters and stat_* at 0;
  - last_grant at N_REGIONS-1;
  - latched data undefined.
REQ-027 Reset mid-transaction SHALL abandon it without emitting a response.

Structure
REQ-028 LISTEN_REQ_BITS, LISTEN_RSP_BITS, the request/response struct typedefs, and TCP_PORT_OFFS SHALL live in lynxTypes.
REQ-029 The state typedef SHALL be local to the module.
REQ-030 The round-robin priority encoder SHALL be one sub-module, rr_arbiter (parameter N, inputs req and last, output one-hot/index grant).

Verification
REQ-031 Reset, then region 0 requests port 5001; table answers success=1 after 3 cycles -> m_rsp_valid[0]=1 with success=1, stat_* = 0.
REQ-032 Regions 1 and 3 both request continuously, answers immediate -> grants alternate 1,3,1,3.
REQ-033 Region 2 requests; no response for 1024 cycles -> m_rsp_valid[2] with success=0, stat_timeouts=1; the late response at cycle 1100 -> stat_dropped=1.
REQ-034 m_req_ready held 0 for 50 cycles -> m_req_valid and data stable throughout, with no s_req_ready to other regions.
REQ-035 Response and timeout in the same cycle -> response data delivered, stat_timeouts unchanged.
REQ-036 Assert aresetn=0 in ST_WAIT -> no m_rsp_valid, all outputs zero next cycle, next grant goes to index 0.
